lsu_data_mem: RTL

- Parametrised successor to the core's flat word data memory.
- Adds RISC-V byte, halfword and word loads/stores selected by funct3, with sign/zero extension and byte-lane write masking.
- Adds misalignment and range fault reporting, plus a valid/ready request port with a configurable, fixed response latency.
- Sits between the core's execute stage (ALU address, rs2 data, funct3) and writeback; the core stalls on req_ready low and captures the load result on rsp_valid.

---
 rtl/lsu_data_mem_if.sv | 22 ++
 rtl/lsu_data_mem.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lsu_data_mem_if.sv
// Request/response bus between the core's execute stage and the load/store data memory.
interface lsu_data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_data_mem.sv
// RISC-V byte/half/word data memory with fault reporting and a fixed-latency
// single-outstanding valid/ready request port.
module lsu_data_mem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic         clock,
    input logic         reset,
    lsu_data_mem_if.slave bus
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  counter;
    logic [3:0]  counter_next;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] off;
    logic [AW-1:0] word_idx;
    logic [1:0]  lane;
    logic        accept;
    logic        in_range;
    logic        misaligned;
    logic        illegal;
    logic        fault;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lanes;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_data;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        req_ready_int;
    logic        rsp_valid_int;

    assign off      = bus.req_addr - BASE_ADDR;
    assign word_idx = off[AW+1:2];
    assign lane     = off[1:0];
    // Addresses below BASE_ADDR wrap to huge offsets and land here as range faults.
    assign in_range = (off >> (AW + 2)) == 32'd0;
    assign accept   = bus.req_valid && req_ready_int;
    assign rd_word  = mem[word_idx];

    always_comb begin
        illegal     = 1'b0;
        misaligned  = 1'b0;
        byte_en     = 4'b0000;
        wdata_lanes = bus.req_wdata;
        load_data   = 32'd0;
        rd_shift    = rd_word >> {lane, 3'b000};
        case (bus.req_funct3[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{bus.req_wdata[7:0]}};
                load_data   = {{24{rd_shift[7] & ~bus.req_funct3[2]}}, rd_shift[7:0]};
            end
            2'b01: begin
                misaligned  = lane[0];
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{bus.req_wdata[15:0]}};
                load_data   = {{16{rd_shift[15] & ~bus.req_funct3[2]}}, rd_shift[15:0]};
            end
            2'b10: begin
                misaligned  = (lane != 2'b00);
                byte_en     = 4'b1111;
                load_data   = rd_word;
                illegal     = bus.req_funct3[2];
            end
            default: illegal = 1'b1;
        endcase
        // Stores have no unsigned variants, so funct3[2] is never legal for them.
        if (bus.req_we && bus.req_funct3[2]) begin
            illegal = 1'b1;
        end
        fault = illegal || misaligned || !in_range;
    end

    always_ff @(posedge clock) begin
        if (accept && bus.req_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q   <= fault;
            rdata_q <= (fault || bus.req_we) ? 32'd0 : load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            counter <= 4'd0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // IDLE and RESP both accept; RESP falls back to IDLE when nothing new arrives.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            WAIT: begin
                if (counter == 4'd1) begin
                    state_next   = RESP;
                    counter_next = 4'd0;
                end else begin
                    counter_next = counter - 4'd1;
                end
            end
            default: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next   = WAIT;
                        counter_next = LAT_M1;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    assign req_ready_int = !reset && (state != WAIT);
    assign rsp_valid_int = !reset && (state == RESP);

    assign bus.req_ready = req_ready_int;
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.rsp_rdata = rsp_valid_int ? rdata_q : 32'd0;
    assign bus.rsp_err   = rsp_valid_int && err_q;

endmodule
